// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared types and constants for the external word feeder
package feeder_pkg;

  localparam int FEEDER_DEPTH = 16;
  localparam int WORD_W       = 10;
  localparam int PTR_W        = $clog2(FEEDER_DEPTH);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_RUN  = 2'd1,
    S_END  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - program word buffer, synchronous write, asynchronous read
module prog_mem #(
  parameter int DEPTH  = 16,
  parameter int WORD_W = 10,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ext_feeder.sv
// rtl/ext_feeder.sv - buffers a switch-entered program and replays it on Ext requests
module ext_feeder #(
  parameter int DEPTH  = feeder_pkg::FEEDER_DEPTH,
  parameter int WORD_W = feeder_pkg::WORD_W,
  parameter int AW     = $clog2(DEPTH),
  parameter int CW     = AW + 1
) (
  input  logic              CLKb,
  input  logic              RSTn,
  input  logic [WORD_W-1:0] D,
  input  logic              LOAD,
  input  logic              WR,
  input  logic              Ext,
  output logic [WORD_W-1:0] Q,
  output logic              OE,
  output logic [AW-1:0]     PC,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              done,
  output logic              underrun
);

  import feeder_pkg::*;

  feeder_state_t     state, state_next;
  logic [CW-1:0]     pc_q;
  logic [CW-1:0]     count_q;
  logic              underrun_q;
  logic [WORD_W-1:0] rdata;
  logic              is_full;
  logic              has_word;
  logic              deliver;
  logic              wr_en;
  logic              last_word;

  // The write address is the low bits of count; count itself saturates at DEPTH.
  assign is_full   = (count_q == CW'(DEPTH));
  assign has_word  = (pc_q < count_q);
  assign deliver   = (state == S_RUN) && Ext && has_word;
  assign wr_en     = (state == S_LOAD) && WR && !is_full;
  assign last_word = deliver && ((pc_q + CW'(1)) == count_q);

  prog_mem #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W),
    .AW     (AW)
  ) u_prog_mem (
    .clk   (CLKb),
    .we    (wr_en),
    .waddr (count_q[AW-1:0]),
    .wdata (D),
    .raddr (pc_q[AW-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge CLKb or negedge RSTn) begin
    if (!RSTn) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_LOAD: if (!LOAD) state_next = S_RUN;
      S_RUN: begin
        if (LOAD) begin
          state_next = S_LOAD;
        end else if ((count_q == '0) || last_word) begin
          state_next = S_END;
        end
      end
      S_END:   if (LOAD) state_next = S_LOAD;
      default: state_next = S_LOAD;
    endcase
  end

  always_comb begin
    OE   = deliver;
    Q    = deliver ? rdata : '0;
    done = (state == S_END);
  end

  // Leaving run/end for load discards the old program; a write on that same edge is dropped.
  always_ff @(posedge CLKb or negedge RSTn) begin
    if (!RSTn) begin
      pc_q       <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
    end else if (state == S_LOAD) begin
      if (wr_en) count_q <= count_q + CW'(1);
      if (!LOAD) pc_q <= '0;
    end else if (LOAD) begin
      pc_q       <= '0;
      count_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (deliver) pc_q <= pc_q + CW'(1);
      if (Ext && !has_word) underrun_q <= 1'b1;
    end
  end

  assign PC       = pc_q[AW-1:0];
  assign count    = count_q;
  assign full     = is_full;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_ext_feeder.sv
// tb/tb_ext_feeder.sv - self-checking bench for ext_feeder with a program-level model
module tb_ext_feeder;
  import feeder_pkg::*;

  localparam int DEPTH = 16;

  logic       CLKb, RSTn, LOAD, WR, Ext;
  logic [9:0] D, Q;
  logic       OE, full, done, underrun;
  logic [3:0] PC;
  logic [4:0] count;

  int n_cmp = 0;
  int n_err = 0;

  // program-level model: stored words, how many were loaded, how many were delivered
  logic [9:0] mem_m [DEPTH];
  int  size, idx;
  bit  running, ended, und_m;
  logic [9:0] words [$];

  ext_feeder dut (
    .CLKb(CLKb), .RSTn(RSTn), .D(D), .LOAD(LOAD), .WR(WR), .Ext(Ext),
    .Q(Q), .OE(OE), .PC(PC), .count(count), .full(full), .done(done),
    .underrun(underrun)
  );

  initial CLKb = 1'b0;
  always #5 CLKb = ~CLKb;

  function automatic bit m_oe();
    return running && Ext && (idx < size);
  endfunction

  function automatic logic [9:0] m_q();
    return m_oe() ? mem_m[idx] : 10'd0;
  endfunction

  task automatic model_reset();
    size = 0; idx = 0; running = 0; ended = 0; und_m = 0;
  endtask

  task automatic model_edge();
    bit del;
    if (!running) begin
      if (WR && size < DEPTH) begin
        mem_m[size] = D;
        size++;
      end
      if (!LOAD) begin
        running = 1; idx = 0; ended = 0;
      end
    end else if (LOAD) begin
      model_reset();
    end else begin
      del = Ext && (idx < size);
      if (Ext && idx >= size) und_m = 1;
      if (idx == size || (del && idx + 1 == size)) ended = 1;
      if (del) idx++;
    end
  endtask

  task automatic drive(input bit ld, input bit wr, input logic [9:0] d, input bit ext);
    LOAD = ld; WR = wr; D = d; Ext = ext;
    #1;
  endtask

  task automatic tick();
    @(posedge CLKb);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    drive(1, 0, 0, 0);
    model_reset();
    @(negedge CLKb);
    RSTn = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    drive(1, 0, 0, 1);
    model_reset();
    n_cmp += 7;
    if (Q !== 10'd0)     begin n_err++; $display("FAIL reset_q: got %h expected 000", Q); end
    if (OE !== 1'b0)     begin n_err++; $display("FAIL reset_oe: got %b expected 0", OE); end
    if (PC !== 4'd0)     begin n_err++; $display("FAIL reset_pc: got %0d expected 0", PC); end
    if (count !== 5'd0)  begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    if (full !== 1'b0)   begin n_err++; $display("FAIL reset_full: got %b expected 0", full); end
    if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    @(negedge CLKb);
    RSTn = 1'b1;
    drive(1, 0, 0, 0);
  endtask

  task automatic test_basic();
    logic [9:0] w [3];
    w[0] = 10'h3A1; w[1] = 10'h042; w[2] = 10'h1FF;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, w[i], 0);
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 1);
      n_cmp += 2;
      if (OE !== 1'b1) begin n_err++; $display("FAIL basic_oe[%0d]: got %b expected 1", i, OE); end
      if (Q !== w[i])  begin n_err++; $display("FAIL basic_q[%0d]: got %h expected %h", i, Q, w[i]); end
      tick();
    end
    drive(0, 0, 0, 0);
    n_cmp += 2;
    if (done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %b expected 1", done); end
    if (PC !== 4'd3)   begin n_err++; $display("FAIL basic_pc: got %0d expected 3", PC); end
  endtask

  task automatic test_full_and_underrun();
    logic [9:0] w;
    do_reset();
    words.delete();
    for (int i = 0; i < 17; i++) begin
      w = 10'($urandom);
      if (i < DEPTH) words.push_back(w);
      drive(1, 1, w, 0);
      tick();
      if (i == 14) begin
        n_cmp++;
        if (full !== 1'b0) begin n_err++; $display("FAIL full_early: got %b expected 0", full); end
      end
      if (i == 15) begin
        n_cmp++;
        if (full !== 1'b1) begin n_err++; $display("FAIL full_at16: got %b expected 1", full); end
      end
    end
    n_cmp += 2;
    if (count !== 5'd16) begin n_err++; $display("FAIL full_count: got %0d expected 16", count); end
    if (full !== 1'b1)   begin n_err++; $display("FAIL full_held: got %b expected 1", full); end
    drive(0, 0, 0, 0);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 0, 0, 1);
      n_cmp += 2;
      if (OE !== 1'b1)     begin n_err++; $display("FAIL full_oe[%0d]: got %b expected 1", i, OE); end
      if (Q !== words[i])  begin n_err++; $display("FAIL full_q[%0d]: got %h expected %h", i, Q, words[i]); end
      tick();
    end
    drive(0, 0, 0, 1);
    n_cmp += 4;
    if (OE !== 1'b0)       begin n_err++; $display("FAIL under_oe: got %b expected 0", OE); end
    if (Q !== 10'd0)       begin n_err++; $display("FAIL under_q: got %h expected 000", Q); end
    if (done !== 1'b1)     begin n_err++; $display("FAIL under_done: got %b expected 1", done); end
    if (underrun !== 1'b0) begin n_err++; $display("FAIL under_pre: got %b expected 0", underrun); end
    tick();
    drive(0, 0, 0, 0);
    tick();
    n_cmp += 2;
    if (underrun !== 1'b1) begin n_err++; $display("FAIL under_sticky: got %b expected 1", underrun); end
    if (done !== 1'b1)     begin n_err++; $display("FAIL under_done2: got %b expected 1", done); end
  endtask

  task automatic test_empty_run();
    drive(1, 0, 0, 0);
    tick();
    n_cmp += 2;
    if (count !== 5'd0)    begin n_err++; $display("FAIL empty_count: got %0d expected 0", count); end
    if (underrun !== 1'b0) begin n_err++; $display("FAIL empty_clr: got %b expected 0", underrun); end
    drive(0, 0, 0, 0);
    tick();
    n_cmp++;
    if (done !== 1'b0) begin n_err++; $display("FAIL empty_done0: got %b expected 0", done); end
    tick();
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL empty_done1: got %b expected 1", done); end
    drive(0, 0, 0, 1);
    n_cmp++;
    if (OE !== 1'b0) begin n_err++; $display("FAIL empty_oe: got %b expected 0", OE); end
    tick();
    n_cmp++;
    if (underrun !== 1'b1) begin n_err++; $display("FAIL empty_under: got %b expected 1", underrun); end
  endtask

  task automatic test_reload();
    drive(1, 1, 10'h2AA, 0);
    tick();
    n_cmp++;
    if (count !== 5'd0) begin n_err++; $display("FAIL reload_nowrite: got %0d expected 0", count); end
    drive(1, 1, 10'h155, 0);
    tick();
    n_cmp++;
    if (count !== 5'd1) begin n_err++; $display("FAIL reload_count: got %0d expected 1", count); end
    drive(0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1);
    n_cmp += 2;
    if (OE !== 1'b1)    begin n_err++; $display("FAIL reload_oe: got %b expected 1", OE); end
    if (Q !== 10'h155)  begin n_err++; $display("FAIL reload_q: got %h expected 155", Q); end
    tick();
    n_cmp++;
    if (done !== 1'b1) begin n_err++; $display("FAIL reload_done: got %b expected 1", done); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 10'($urandom), 0);
      tick();
    end
    drive(0, 0, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1);
      tick();
    end
    drive(0, 0, 0, 1);
    n_cmp += 2;
    if (PC !== 4'd2) begin n_err++; $display("FAIL mid_pc: got %0d expected 2", PC); end
    if (OE !== 1'b1) begin n_err++; $display("FAIL mid_oe: got %b expected 1", OE); end
    #2 RSTn = 1'b0;
    #1;
    n_cmp += 8;
    if (Q !== 10'd0)       begin n_err++; $display("FAIL mid_q: got %h expected 000", Q); end
    if (OE !== 1'b0)       begin n_err++; $display("FAIL mid_oe_rst: got %b expected 0", OE); end
    if (PC !== 4'd0)       begin n_err++; $display("FAIL mid_pc_rst: got %0d expected 0", PC); end
    if (count !== 5'd0)    begin n_err++; $display("FAIL mid_count: got %0d expected 0", count); end
    if (full !== 1'b0)     begin n_err++; $display("FAIL mid_full: got %b expected 0", full); end
    if (done !== 1'b0)     begin n_err++; $display("FAIL mid_done: got %b expected 0", done); end
    if (underrun !== 1'b0) begin n_err++; $display("FAIL mid_under: got %b expected 0", underrun); end
    if (dut.state !== S_LOAD) begin n_err++; $display("FAIL mid_state: got %0d expected %0d", dut.state, S_LOAD); end
    model_reset();
    drive(1, 0, 0, 0);
    @(negedge CLKb);
    RSTn = 1'b1;
    #1;
  endtask

  task automatic test_random();
    bit ld;
    do_reset();
    ld = 1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 19) == 0) ld = !ld;
      drive(ld, ($urandom_range(0, 3) != 0), 10'($urandom), ($urandom_range(0, 2) != 0));
      n_cmp += 7;
      if (OE !== m_oe())           begin n_err++; $display("FAIL rnd_oe@%0d: got %b expected %b", c, OE, m_oe()); end
      if (Q !== m_q())             begin n_err++; $display("FAIL rnd_q@%0d: got %h expected %h", c, Q, m_q()); end
      if (PC !== 4'(idx))          begin n_err++; $display("FAIL rnd_pc@%0d: got %0d expected %0d", c, PC, 4'(idx)); end
      if (count !== 5'(size))      begin n_err++; $display("FAIL rnd_count@%0d: got %0d expected %0d", c, count, size); end
      if (full !== (size == DEPTH)) begin n_err++; $display("FAIL rnd_full@%0d: got %b expected %b", c, full, size == DEPTH); end
      if (done !== ended)          begin n_err++; $display("FAIL rnd_done@%0d: got %b expected %b", c, done, ended); end
      if (underrun !== und_m)      begin n_err++; $display("FAIL rnd_under@%0d: got %b expected %b", c, underrun, und_m); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_and_underrun();
    test_empty_run();
    test_reload();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ext_feeder.md
# ext_feeder

External instruction and immediate source for the 10-bit processor. It is the writer side of the data bus's external path. It buffers a short program entered from the `D` switches. In run mode it answers each controller `Ext` request by driving the next buffered word onto the shared bus, so the instruction register and the register file receive a scripted word stream without manual switch changes between steps. It sits beside the controller and drives the bus through its own output-enable.

## Interface
Parameters:
- `DEPTH`, 16: number of program words buffered; power of two.
- `WORD_W`, 10: bus word width.

Ports:
- `CLKb`, input, 1: processor clock (debounced step clock); all state changes on its rising edge.
- `RSTn`, input, 1: asynchronous reset, active-low.
- `D`, input, `WORD_W`: switch word written into the buffer during load.
- `LOAD`, input, 1: level; 1 selects load mode, 0 selects run mode.
- `WR`, input, 1: write strobe; sampled on `CLKb` edge in load mode.
- `Ext`, input, 1: controller request for an external word in the current timestep.
- `Q`, output, `WORD_W`: word to the shared bus; 0 whenever `OE`=0.
- `OE`, output, 1: bus drive enable; the top level tri-states `Q` onto the bus with it.
- `PC`, output, log2(`DEPTH`): read pointer, for display.
- `count`, output, log2(`DEPTH`)+1: number of words loaded.
- `full`, output, 1: `count` equals `DEPTH`.
- `done`, output, 1: every loaded word has been delivered.
- `underrun`, output, 1: sticky; `Ext` arrived with no word left.

## Operation
- FSM states: `S_LOAD`, `S_RUN`, `S_END`.
- Reset: state `S_LOAD`, `wptr`=0, `PC`=0, `count`=0, `underrun`=0.
- Reset values of outputs: `Q`=0, `OE`=0, `PC`=0, `count`=0, `full`=0, `done`=0, `underrun`=0.
- Buffer contents are not reset. They are unreachable while `count`=0.
- `S_LOAD` behaviour:
  - `WR`=1 and not `full`: write `mem[wptr]`=`D`, then increment `wptr` and `count`.
  - `WR`=1 while `full`: ignored, no wrap.
  - `Ext` is ignored, with `OE`=0.
  - `LOAD`=0: go to `S_RUN` with `PC`=0.
- `S_RUN` behaviour:
  - `Ext`=1 and `PC`<`count`: `OE`=1, `Q`=`mem[PC]`, and `PC` increments at the edge.
  - If that increment makes `PC` equal `count`, the next state is `S_END`.
  - `S_RUN` with `count`=0 goes to `S_END` immediately.
- `S_END` behaviour: `done`=1.
  - `Ext`=1 drives `OE`=0 and `Q`=0, and sets `underrun`.
- `LOAD`=1 in `S_RUN` or `S_END`:
  - Go to `S_LOAD`.
  - Clear `wptr`, `count`, `PC` and `underrun`; this starts a new program.
- `WR` outside `S_LOAD` is ignored.
- `PC` never wraps. `wptr` saturates at `DEPTH`, which is held in `count`.

## Timing
- `Q` and `OE` are combinational from registered state, `PC` and `Ext`. This gives zero-cycle latency, so the word is on the bus in the same timestep the controller raises `Ext`.
- The buffer uses asynchronous read and synchronous write.
- An `Ext` held high for N consecutive edges in `S_RUN` delivers N consecutive words, one per cycle, then stops at `S_END`.
- `LOAD` and `WR` high on the same edge in `S_RUN` or `S_END`: perform the mode change only; no write happens on that edge.
- `RSTn` assertion mid-run: outputs go to reset values immediately, without waiting for a clock edge. Deassertion is synchronised upstream.

## Structure
- `feeder_pkg` holds:
  - the state enum `feeder_state_t` (`S_LOAD`, `S_RUN`, `S_END`);
  - the constants `FEEDER_DEPTH`=16 and `WORD_W`=10;
  - the derived pointer width.
- One sub-module, `prog_mem`: a `DEPTH` x `WORD_W` array with synchronous write and asynchronous read.
- The FSM, pointers and output muxing live in `ext_feeder`.

## Test plan
- Reset, then load 3 words (0x3A1, 0x042, 0x1FF), then set `LOAD`=0 and pulse `Ext` three times. Expect `Q`=0x3A1, 0x042, 0x1FF with `OE`=1 on each pulse, then `done`=1 and `PC`=3.
- Write 17 words with `WR`. Expect `full`=1 after the 16th write, the 17th ignored, and `count`=16.
- After the program is exhausted, assert `Ext` again. Expect `OE`=0, `Q`=0, `underrun`=1 held, and `done`=1.
- Enter `S_RUN` with no words loaded. Expect `done`=1 on the next edge; `Ext` then sets `underrun`.
- Mid-run at `PC`=2, drop `RSTn` between clock edges. Expect all outputs at reset values immediately and the state at `S_LOAD`.
- From `S_END`, raise `LOAD`, write 0x155, then run. Expect `count`=1 and `Q`=0x155 on the first `Ext`.
